// File: rtl/secded_pkg.sv
// secded_pkg: shared constants, status enum and helper functions for the
// 32-bit SECDED read path (39-bit codeword: 32 data, 6 Hamming parity bits,
// 1 overall-parity bit at index 38).
package secded_pkg;

    localparam int M     = 32;  // data width
    localparam int P     = 7;   // check bits (6 Hamming + overall)
    localparam int CW_W  = 39;  // codeword width
    localparam int SYN_W = 6;   // Hamming syndrome width

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } secded_status_e;

    // True for indices that carry check bits rather than data: the Hamming
    // positions 1,2,4,8,16,32 (index = position - 1) and the overall bit.
    function automatic logic is_parity_idx(input logic [5:0] idx);
        return (idx == 6'd0)  || (idx == 6'd1)  || (idx == 6'd3) ||
               (idx == 6'd7)  || (idx == 6'd15) || (idx == 6'd31) ||
               (idx == 6'd38);
    endfunction

    // Gather the 32 data bits from the non-check indices in ascending order.
    function automatic logic [M-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [M-1:0] d;
        logic [5:0]   k;
        d = '0;
        k = 6'd0;
        for (int i = 0; i < CW_W; i++) begin
            if (!is_parity_idx(6'(i))) begin
                d[k[4:0]] = cw[i];
                k         = k + 6'd1;
            end
        end
        return d;
    endfunction

    // Syndrome bit k: XOR of cw[i] over indices 0..37 whose position (i+1)
    // has bit k set. The overall-parity bit never contributes.
    function automatic logic syn_bit(input logic [CW_W-1:0] cw, input logic [2:0] k);
        logic       acc;
        logic [5:0] pos;
        acc = 1'b0;
        for (int i = 0; i < CW_W - 1; i++) begin
            pos = 6'(i + 1);
            acc = acc ^ (cw[i] & pos[k]);
        end
        return acc;
    endfunction

    // Overall even-parity check across the whole codeword.
    function automatic logic calc_parity(input logic [CW_W-1:0] cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational syndrome / overall-parity generator placed
// in front of the decoder's first register stage.
//   in_cw : 39-bit codeword
//   syn   : 6-bit Hamming syndrome (0 = no Hamming error)
//   p     : overall parity of all 39 bits (0 for a clean word)
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]  in_cw,
    output logic [SYN_W-1:0] syn,
    output logic             p
);

    // Compute each syndrome bit and the overall parity.
    always_comb begin
        syn = '0;
        for (int k = 0; k < SYN_W; k++) begin
            syn[k] = syn_bit(in_cw, 3'(k));
        end
        p = calc_parity(in_cw);
    end

endmodule

// File: rtl/secded_decoder.sv
// secded_decoder: two-stage pipelined SECDED checker/corrector.
//   S1 holds the codeword with its syndrome and overall parity; S2 holds the
//   corrected data and status flags that drive the outputs directly.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : codeword handshake (in_ready is combinational)
//   in_cw                 : 39-bit codeword
//   out_valid/out_ready   : decoded-word handshake
//   out_data              : corrected (or raw, if uncorrectable) data
//   out_corr/out_uncorr   : single-bit corrected / uncorrectable flags
//   out_err_pos           : 1-based flipped-bit position, 0 when none
//   cnt_clr               : clears counters and last_syn (wins over updates)
//   corr_cnt/uncorr_cnt   : saturating error counters
//   last_syn              : {p, syn} of the latest erroneous word delivered
module secded_decoder
    import secded_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic [5:0]       out_err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic [6:0]       last_syn
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYN_W-1:0] syn_s;
    logic             p_s;

    logic             s1_valid_r;
    logic [CW_W-1:0]  s1_cw_r;
    logic [SYN_W-1:0] s1_syn_r;
    logic             s1_p_r;

    logic [6:0]       s2_syn_r;

    logic             s2_load_s;
    logic             out_hs_s;
    secded_status_e   status_s;
    logic [5:0]       pos_s;
    logic [CW_W-1:0]  flip_s;
    logic [M-1:0]     data_s;
    logic             corr_s;
    logic             uncorr_s;

    secded_syndrome u_syndrome (
        .in_cw (in_cw),
        .syn   (syn_s),
        .p     (p_s)
    );

    // S2 takes a new word whenever it is empty or its word leaves this cycle;
    // S1 advances on the same condition, so at most two words are held.
    assign s2_load_s = !out_valid || out_ready;
    assign in_ready  = !s1_valid_r || s2_load_s;
    assign out_hs_s  = out_valid && out_ready;

    // S1: capture the codeword together with its syndrome and parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_cw_r    <= '0;
            s1_syn_r   <= '0;
            s1_p_r     <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_cw_r  <= in_cw;
                s1_syn_r <= syn_s;
                s1_p_r   <= p_s;
            end else begin
                s1_cw_r  <= s1_cw_r;
                s1_syn_r <= s1_syn_r;
                s1_p_r   <= s1_p_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Classify the S1 word and build the single-bit correction mask.
    // A syndrome of zero with odd parity means only the overall bit flipped,
    // which carries no data, so no mask is applied in that case.
    always_comb begin
        status_s = CLEAN;
        pos_s    = 6'd0;
        flip_s   = '0;
        if (s1_syn_r == 6'd0) begin
            if (s1_p_r) begin
                status_s = CORR;
                pos_s    = 6'd39;
            end else begin
                status_s = CLEAN;
            end
        end else if (s1_p_r) begin
            if (s1_syn_r <= 6'd38) begin
                status_s = CORR;
                pos_s    = s1_syn_r;
                flip_s   = 39'd1 << (s1_syn_r - 6'd1);
            end else begin
                status_s = UNCORR;
            end
        end else begin
            status_s = UNCORR;
        end
    end

    // Decode status into flags; uncorrectable words keep the raw data.
    always_comb begin
        data_s = extract_data(s1_cw_r ^ flip_s);
        case (status_s)
            CORR: begin
                corr_s   = 1'b1;
                uncorr_s = 1'b0;
            end
            UNCORR: begin
                corr_s   = 1'b0;
                uncorr_s = 1'b1;
            end
            default: begin
                corr_s   = 1'b0;
                uncorr_s = 1'b0;
            end
        endcase
    end

    // S2: output register; holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_corr    <= 1'b0;
            out_uncorr  <= 1'b0;
            out_err_pos <= 6'd0;
            s2_syn_r    <= 7'd0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data    <= data_s;
                out_corr    <= corr_s;
                out_uncorr  <= uncorr_s;
                out_err_pos <= pos_s;
                s2_syn_r    <= {s1_p_r, s1_syn_r};
            end else begin
                out_data    <= out_data;
                out_corr    <= out_corr;
                out_uncorr  <= out_uncorr;
                out_err_pos <= out_err_pos;
                s2_syn_r    <= s2_syn_r;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

    // Error statistics, updated only when a word is actually delivered.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            last_syn   <= 7'd0;
        end else if (out_hs_s) begin
            if (out_corr && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end else begin
                corr_cnt <= corr_cnt;
            end
            if (out_uncorr && (uncorr_cnt != CNT_MAX)) begin
                uncorr_cnt <= uncorr_cnt + CNT_ONE;
            end else begin
                uncorr_cnt <= uncorr_cnt;
            end
            if (out_corr || out_uncorr) begin
                last_syn <= s2_syn_r;
            end else begin
                last_syn <= last_syn;
            end
        end else begin
            corr_cnt   <= corr_cnt;
            uncorr_cnt <= uncorr_cnt;
            last_syn   <= last_syn;
        end
    end

endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: directed self-checking bench for secded_decoder.
// A second instance with 2-bit counters exercises saturation; both share
// the same stimulus.
module tb_secded_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [38:0] in_cw = 39'd0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;

    logic        in_ready, out_valid, out_corr, out_uncorr;
    logic [31:0] out_data;
    logic [5:0]  out_err_pos;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic [6:0]  last_syn;

    logic        sat_in_ready, sat_out_valid, sat_out_corr, sat_out_uncorr;
    logic [31:0] sat_out_data;
    logic [5:0]  sat_out_err_pos;
    logic [1:0]  sat_corr_cnt, sat_uncorr_cnt;
    logic [6:0]  sat_last_syn;

    int n_checks = 0;
    int n_fail   = 0;

    secded_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr),
        .out_err_pos(out_err_pos), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt), .last_syn(last_syn)
    );

    secded_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_cw(in_cw), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_data(sat_out_data), .out_corr(sat_out_corr), .out_uncorr(sat_out_uncorr),
        .out_err_pos(sat_out_err_pos), .cnt_clr(cnt_clr), .corr_cnt(sat_corr_cnt),
        .uncorr_cnt(sat_uncorr_cnt), .last_syn(sat_last_syn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden Hamming encoder: data in non-power-of-two positions, parity
    // bit at position 2^b covers positions with bit b set, even overall bit.
    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [38:0] cw;
        int          k;
        logic        par;
        cw = 39'd0;
        k  = 0;
        for (int i = 0; i < 38; i++) begin
            if (((i + 1) & i) != 0) begin
                cw[i] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            par = 1'b0;
            for (int i = 0; i < 38; i++) begin
                if ((((i + 1) >> b) & 1) == 1) par = par ^ cw[i];
            end
            cw[(1 << b) - 1] = par;
        end
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    // Push one word through with out_ready high and check the result.
    // clr asserts cnt_clr across the output handshake edge. Returns one
    // negedge after that handshake so counters are already updated.
    task automatic send_one(input string tag, input logic [38:0] cw, input logic [31:0] ed,
                            input logic ec, input logic eu, input logic [5:0] ep, input logic clr);
        int t;
        @(negedge clk);
        in_cw    = cw;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, {63'd0, out_valid}, 64'd1);
        end else begin
            check({tag, "_data"},   {32'd0, out_data}, {32'd0, ed});
            check({tag, "_corr"},   {63'd0, out_corr}, {63'd0, ec});
            check({tag, "_uncorr"}, {63'd0, out_uncorr}, {63'd0, eu});
            check({tag, "_pos"},    {58'd0, out_err_pos}, {58'd0, ep});
        end
        cnt_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    logic [31:0] d;
    logic [31:0] bp_d [4];
    logic [31:0] got_q [$];
    int          idx;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        check("rst_out_data",  {32'd0, out_data}, 64'd0);
        check("rst_flags",     {62'd0, out_corr, out_uncorr}, 64'd0);
        check("rst_pos",       {58'd0, out_err_pos}, 64'd0);
        check("rst_cnts",      {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
        check("rst_last_syn",  {57'd0, last_syn}, 64'd0);

        // Clean words
        send_one("zero", 39'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        for (int n = 0; n < 1000; n++) begin
            d = $urandom;
            send_one("rand_clean", enc(d), d, 1'b0, 1'b0, 6'd0, 1'b0);
        end
        check("clean_cnts", {32'd0, corr_cnt, uncorr_cnt}, 64'd0);

        // Single data-bit error at position 3
        send_one("flip_d0", 39'h4, 32'd0, 1'b1, 1'b0, 6'd3, 1'b0);
        check("flip_d0_cnt", {48'd0, corr_cnt}, 64'd1);
        check("flip_d0_syn", {57'd0, last_syn}, 64'h43);

        // Overall-parity bit only
        send_one("flip_p", 39'h40_0000_0000, 32'd0, 1'b1, 1'b0, 6'd39, 1'b0);
        check("flip_p_cnt", {48'd0, corr_cnt}, 64'd2);
        check("flip_p_syn", {57'd0, last_syn}, 64'h40);

        // Double error: positions 2 and 3 -> s=1, p=0
        send_one("dbl", 39'h6, 32'h1, 1'b0, 1'b1, 6'd0, 1'b0);
        check("dbl_cnt", {48'd0, uncorr_cnt}, 64'd1);
        check("dbl_syn", {57'd0, last_syn}, 64'h01);

        // Syndrome 40 with odd parity: positions 32, 8 and the overall bit
        send_one("s40", 39'h40_8000_0080, 32'd0, 1'b0, 1'b1, 6'd0, 1'b0);
        check("s40_cnt", {48'd0, uncorr_cnt}, 64'd2);
        check("s40_syn", {57'd0, last_syn}, 64'h68);

        // Every single flip on one random word
        d = $urandom;
        for (int j = 0; j < 39; j++) begin
            send_one("sweep", enc(d) ^ (39'd1 << j), d, 1'b1, 1'b0, 6'(j + 1), 1'b0);
        end
        check("sweep_cnt",     {48'd0, corr_cnt}, 64'd41);
        check("sweep_syn",     {57'd0, last_syn}, 64'h40);
        check("sat_early_cnt", {60'd0, sat_corr_cnt, sat_uncorr_cnt}, 64'hE);

        // Clear, then saturate a 2-bit counter
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_cnts",     {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
        check("clr_sat_cnts", {60'd0, sat_corr_cnt, sat_uncorr_cnt}, 64'd0);
        check("clr_syn",      {57'd0, last_syn}, 64'd0);
        for (int j = 0; j < 5; j++) begin
            d = $urandom;
            send_one("sat", enc(d) ^ (39'd1 << (j + 4)), d, 1'b1, 1'b0, 6'(j + 5), 1'b0);
        end
        check("sat_cnt",  {62'd0, sat_corr_cnt}, 64'd3);
        check("wide_cnt", {48'd0, corr_cnt}, 64'd5);
        d = $urandom;
        send_one("sat_clr", enc(d) ^ 39'h10, d, 1'b1, 1'b0, 6'd5, 1'b1);
        check("sat_clr_cnt",  {62'd0, sat_corr_cnt}, 64'd0);
        check("wide_clr_cnt", {48'd0, corr_cnt}, 64'd0);
        check("sat_clr_syn",  {57'd0, sat_last_syn}, 64'd0);

        // Backpressure: 4 words offered with out_ready low, released later
        bp_d[0] = 32'h1111_1111;
        bp_d[1] = 32'h2222_2222;
        bp_d[2] = 32'hDEAD_BEEF;
        bp_d[3] = 32'h0F0F_A5A5;
        idx = 0;
        for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            in_valid  = (idx < 4);
            in_cw     = (idx < 4) ? enc(bp_d[idx]) : 39'd0;
            #1;
            if (c == 2) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            if (c == 4) check("bp_hold_data", {32'd0, out_data}, {32'd0, bp_d[0]});
            if (c == 5) check("bp_accepted", 64'(idx), 64'd2);
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            check("bp_order", {32'd0, got_q[k]}, {32'd0, bp_d[k]});
        end

        // Reset with two words in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_cw    = enc(bp_d[k]) ^ 39'h4;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_full", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_cnts",  {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_ghost",  {63'd0, out_valid}, 64'd0);
        check("mid_cnts_stay", {32'd0, corr_cnt, uncorr_cnt}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
